instruction_fetch_unit: RTL and testbench

- Instruction-fetch stage of the MIPS datapath. Owns the fetch PC and drives the instruction memory through a req/ack handshake.
- Produces the IF/ID register values Instruction and PCPlus4Address. These feed decode and the jump-address calculation.
- Accepts redirects (jump, branch, jr targets) from downstream. Supports downstream stall, with a one-entry hold buffer so a returned instruction is never lost.

---
 rtl/instruction_fetch_unit_if.sv | 22 ++
 rtl/instruction_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and
// the instruction memory. The fetch unit is the master.
interface instruction_fetch_unit_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemRdata;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemAck,
        input  ImemRdata
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemAck,
        output ImemRdata
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, talks to instruction memory
// over a req/ack bus and fills the IF/ID register. Downstream redirects
// restart the fetch stream; a one-entry hold buffer keeps a returned word
// while decode is stalled.
//
// state | meaning
// ------+----------------------------------------------------------------
// FETCH | request outstanding on fetch_pc; ack loads IF/ID or hold buffer
// DRAIN | redirect seen before ack; wait for the stale ack, then restart
// HOLD  | word parked in hold buffer while decode stalls; no request
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Stall,
    input  logic                     Redirect,
    input  logic [31:0]              RedirectTarget,
    instruction_fetch_unit_if.master imem,
    output logic [31:0]              Instruction,
    output logic [31:0]              PCPlus4Address,
    output logic                     InstrValid
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] next_pc;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc_plus4;

    logic [31:0] fetch_pc_plus4;
    logic [31:0] redirect_pc;
    logic        if_id_free;

    assign redirect_pc    = {RedirectTarget[31:2], 2'b00};
    assign fetch_pc_plus4 = fetch_pc + 32'd4;
    assign if_id_free     = !InstrValid || !Stall;

    // Request is gated by Rst so the bus is idle during the reset cycle
    // itself, not only from the cycle after it.
    assign imem.ImemReq  = Rst && (state != HOLD);
    assign imem.ImemAddr = fetch_pc;

    // Fetch sequencer: PC, drain target, hold buffer and IF/ID register.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state          <= FETCH;
            fetch_pc       <= RESET_PC_ALIGNED;
            next_pc        <= RESET_PC_ALIGNED;
            hold_instr     <= 32'd0;
            hold_pc_plus4  <= 32'd0;
            Instruction    <= 32'd0;
            PCPlus4Address <= 32'd0;
            InstrValid     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (Redirect) begin
                        InstrValid <= 1'b0;
                        if (imem.ImemAck) begin
                            // Stale word returned in the redirect cycle: drop it
                            // and request the target right away.
                            fetch_pc <= redirect_pc;
                        end else begin
                            // The in-flight request must still complete on its
                            // original address before the target can be issued.
                            next_pc <= redirect_pc;
                            state   <= DRAIN;
                        end
                    end else if (imem.ImemAck) begin
                        if (if_id_free) begin
                            Instruction    <= imem.ImemRdata;
                            PCPlus4Address <= fetch_pc_plus4;
                            InstrValid     <= 1'b1;
                            fetch_pc       <= fetch_pc_plus4;
                        end else begin
                            hold_instr    <= imem.ImemRdata;
                            hold_pc_plus4 <= fetch_pc_plus4;
                            state         <= HOLD;
                        end
                    end else if (if_id_free) begin
                        InstrValid <= 1'b0;
                    end
                end

                DRAIN: begin
                    InstrValid <= 1'b0;
                    if (imem.ImemAck) begin
                        // A redirect arriving with the stale ack is the newest
                        // target and wins over the stored one.
                        fetch_pc <= Redirect ? redirect_pc : next_pc;
                        state    <= FETCH;
                    end else if (Redirect) begin
                        next_pc <= redirect_pc;
                    end
                end

                HOLD: begin
                    if (Redirect) begin
                        fetch_pc   <= redirect_pc;
                        InstrValid <= 1'b0;
                        state      <= FETCH;
                    end else if (!Stall) begin
                        // fetch_pc still addresses the buffered word, so the
                        // next fetch is its successor.
                        Instruction    <= hold_instr;
                        PCPlus4Address <= hold_pc_plus4;
                        InstrValid     <= 1'b1;
                        fetch_pc       <= fetch_pc_plus4;
                        state          <= FETCH;
                    end
                end

                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run checked against a program-order reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;
    localparam logic [31:0] NO_SLOW  = 32'hFFFF_FFFF;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectTarget = 32'd0;
    logic [31:0] Instruction;
    logic [31:0] PCPlus4Address;
    logic        InstrValid;

    instruction_fetch_unit_if imem_bus ();

    instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Stall          (Stall),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .imem           (imem_bus),
        .Instruction    (Instruction),
        .PCPlus4Address (PCPlus4Address),
        .InstrValid     (InstrValid)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Memory model: per-request latency, data = addr ^ KEY.
    logic [31:0] slow_addr = NO_SLOW;
    int          slow_lat  = 0;
    bit          mem_rand  = 1'b0;
    bit          mem_pending = 1'b0;
    int          mem_cnt   = 0;

    always @(negedge Clk) begin
        #1;
        if (imem_bus.ImemReq === 1'b1) begin
            if (!mem_pending) begin
                mem_pending = 1'b1;
                if (imem_bus.ImemAddr == slow_addr) mem_cnt = slow_lat;
                else if (mem_rand) mem_cnt = int'($urandom_range(0, 3));
                else mem_cnt = 0;
            end
            if (mem_cnt == 0) begin
                imem_bus.ImemAck   = 1'b1;
                imem_bus.ImemRdata = imem_bus.ImemAddr ^ KEY;
                mem_pending = 1'b0;
            end else begin
                imem_bus.ImemAck   = 1'b0;
                imem_bus.ImemRdata = $urandom;
                mem_cnt = mem_cnt - 1;
            end
        end else begin
            imem_bus.ImemAck   = 1'b0;
            imem_bus.ImemRdata = $urandom;
            mem_pending = 1'b0;
        end
    end

    // One cycle: drive inputs on the falling edge, settle, then caller samples.
    task automatic drive_cycle(input logic rst_v, input logic st, input logic rd, input logic [31:0] tgt);
        @(negedge Clk);
        Rst = rst_v;
        Stall = st;
        Redirect = rd;
        RedirectTarget = tgt;
        #2;
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Rst = 1'b0;
        Stall = 1'b0;
        Redirect = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        slow_addr = NO_SLOW;
        mem_rand = 1'b0;
        apply_reset();
        #2;
        checks++;
        if (imem_bus.ImemReq !== 1'b0) begin
            errors++; $display("FAIL reset_req: got %b expected 0", imem_bus.ImemReq);
        end
        checks++;
        if (InstrValid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", InstrValid);
        end
        checks++;
        if (Instruction !== 32'd0 || PCPlus4Address !== 32'd0) begin
            errors++; $display("FAIL reset_ifid: got %h/%h expected 0/0", Instruction, PCPlus4Address);
        end
        checks++;
        if (imem_bus.ImemAddr !== RESET_PC) begin
            errors++; $display("FAIL reset_addr: got %h expected %h", imem_bus.ImemAddr, RESET_PC);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] e_addr, e_pc4;
        logic        e_valid;
        slow_addr = NO_SLOW;
        mem_rand = 1'b0;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
            e_addr  = 32'(4 * k);
            e_valid = (k >= 1);
            e_pc4   = 32'(4 * k);
            checks++;
            if (imem_bus.ImemAddr !== e_addr || imem_bus.ImemReq !== 1'b1) begin
                errors++; $display("FAIL zw_addr k=%0d: got %h req=%b expected %h req=1", k, imem_bus.ImemAddr, imem_bus.ImemReq, e_addr);
            end
            checks++;
            if (InstrValid !== e_valid) begin
                errors++; $display("FAIL zw_valid k=%0d: got %b expected %b", k, InstrValid, e_valid);
            end
            if (e_valid) begin
                checks++;
                if (PCPlus4Address !== e_pc4 || Instruction !== ((e_pc4 - 32'd4) ^ KEY)) begin
                    errors++; $display("FAIL zw_ifid k=%0d: got %h/%h expected %h/%h", k, Instruction, PCPlus4Address, (e_pc4 - 32'd4) ^ KEY, e_pc4);
                end
            end
        end
    endtask

    task automatic test_delayed_ack();
        logic [31:0] e_addr, e_pc4;
        logic        e_valid;
        slow_addr = 32'h10;
        slow_lat  = 3;
        mem_rand  = 1'b0;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
            if (k < 4)       e_addr = 32'(4 * k);
            else if (k <= 7) e_addr = 32'h10;
            else             e_addr = 32'h10 + 32'(4 * (k - 7));
            e_valid = (k >= 1 && k <= 4) || (k >= 8);
            e_pc4   = (k <= 4) ? 32'(4 * k) : 32'h14 + 32'(4 * (k - 8));
            checks++;
            if (imem_bus.ImemAddr !== e_addr) begin
                errors++; $display("FAIL dly_addr k=%0d: got %h expected %h", k, imem_bus.ImemAddr, e_addr);
            end
            checks++;
            if (InstrValid !== e_valid) begin
                errors++; $display("FAIL dly_valid k=%0d: got %b expected %b", k, InstrValid, e_valid);
            end
            if (e_valid) begin
                checks++;
                if (PCPlus4Address !== e_pc4 || Instruction !== ((e_pc4 - 32'd4) ^ KEY)) begin
                    errors++; $display("FAIL dly_ifid k=%0d: got %h/%h expected pc4 %h", k, Instruction, PCPlus4Address, e_pc4);
                end
            end
        end
        slow_addr = NO_SLOW;
    endtask

    task automatic test_stall_hold();
        logic [31:0] e_pc4;
        logic        e_req, st;
        slow_addr = NO_SLOW;
        mem_rand = 1'b0;
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            st = (k >= 2 && k <= 4);
            drive_cycle(1'b1, st, 1'b0, 32'd0);
            e_req = !(k >= 3 && k <= 5);
            if (k <= 2)      e_pc4 = 32'(4 * k);
            else if (k <= 5) e_pc4 = 32'h8;
            else             e_pc4 = 32'(4 * k - 12);
            checks++;
            if (imem_bus.ImemReq !== e_req) begin
                errors++; $display("FAIL hold_req k=%0d: got %b expected %b", k, imem_bus.ImemReq, e_req);
            end
            if (e_req) begin
                checks++;
                if (imem_bus.ImemAddr !== e_pc4) begin
                    errors++; $display("FAIL hold_addr k=%0d: got %h expected %h", k, imem_bus.ImemAddr, e_pc4);
                end
            end
            if (k >= 1) begin
                checks++;
                if (InstrValid !== 1'b1 || PCPlus4Address !== e_pc4 || Instruction !== ((e_pc4 - 32'd4) ^ KEY)) begin
                    errors++; $display("FAIL hold_ifid k=%0d: got v=%b %h/%h expected pc4 %h", k, InstrValid, Instruction, PCPlus4Address, e_pc4);
                end
            end
        end
    endtask

    task automatic test_redirect_drain();
        logic [31:0] fin, tgt;
        logic        rd;
        slow_addr = 32'h20;
        slow_lat  = 2;
        mem_rand  = 1'b0;
        for (int v = 0; v < 3; v++) begin
            fin = (v == 0) ? 32'h0040_0100 : (v == 1) ? 32'h0000_0304 : 32'h0000_0508;
            apply_reset();
            for (int k = 0; k < 13; k++) begin
                rd  = (k == 8) || (k == 9 && v >= 1) || (k == 10 && v == 2);
                tgt = (k == 8) ? 32'h0040_0103 : (k == 9) ? 32'h0000_0305 : 32'h0000_050A;
                drive_cycle(1'b1, 1'b0, rd, tgt);
                if (k <= 8) begin
                    checks++;
                    if (imem_bus.ImemAddr !== 32'(4 * k) || (k >= 1 && PCPlus4Address !== 32'(4 * k))) begin
                        errors++; $display("FAIL rd_pre v=%0d k=%0d: got addr %h pc4 %h", v, k, imem_bus.ImemAddr, PCPlus4Address);
                    end
                end else if (k <= 10) begin
                    checks++;
                    if (imem_bus.ImemAddr !== 32'h20 || imem_bus.ImemReq !== 1'b1 || InstrValid !== 1'b0) begin
                        errors++; $display("FAIL rd_drain v=%0d k=%0d: got addr %h req %b valid %b expected 20/1/0", v, k, imem_bus.ImemAddr, imem_bus.ImemReq, InstrValid);
                    end
                end else if (k == 11) begin
                    checks++;
                    if (imem_bus.ImemAddr !== fin || InstrValid !== 1'b0) begin
                        errors++; $display("FAIL rd_restart v=%0d: got addr %h valid %b expected %h/0", v, imem_bus.ImemAddr, InstrValid, fin);
                    end
                end else begin
                    checks++;
                    if (InstrValid !== 1'b1 || PCPlus4Address !== fin + 32'd4 || Instruction !== (fin ^ KEY)) begin
                        errors++; $display("FAIL rd_first v=%0d: got v=%b %h/%h expected %h/%h", v, InstrValid, Instruction, PCPlus4Address, fin ^ KEY, fin + 32'd4);
                    end
                end
            end
        end
        slow_addr = NO_SLOW;
    endtask

    task automatic test_redirect_stall();
        logic [31:0] tgt;
        logic        st, rd;
        int          rk;
        slow_addr = NO_SLOW;
        mem_rand = 1'b0;
        for (int v = 0; v < 2; v++) begin
            rk  = 3 + v;
            tgt = (v == 0) ? 32'h0000_1000 : 32'h0000_2000;
            apply_reset();
            for (int k = 0; k <= rk + 2; k++) begin
                st = (k >= 3 && k <= rk);
                rd = (k == rk);
                drive_cycle(1'b1, st, rd, tgt);
                if (k == rk) begin
                    checks++;
                    if (InstrValid !== 1'b1 || PCPlus4Address !== 32'hC) begin
                        errors++; $display("FAIL rs_before v=%0d: got v=%b pc4 %h expected 1/0000000c", v, InstrValid, PCPlus4Address);
                    end
                    checks++;
                    if (imem_bus.ImemReq !== (v == 0)) begin
                        errors++; $display("FAIL rs_req v=%0d: got %b expected %b", v, imem_bus.ImemReq, (v == 0));
                    end
                end else if (k == rk + 1) begin
                    checks++;
                    if (InstrValid !== 1'b0 || imem_bus.ImemAddr !== tgt || imem_bus.ImemReq !== 1'b1) begin
                        errors++; $display("FAIL rs_flush v=%0d: got v=%b addr %h req %b expected 0/%h/1", v, InstrValid, imem_bus.ImemAddr, imem_bus.ImemReq, tgt);
                    end
                end else if (k == rk + 2) begin
                    checks++;
                    if (InstrValid !== 1'b1 || PCPlus4Address !== tgt + 32'd4 || Instruction !== (tgt ^ KEY)) begin
                        errors++; $display("FAIL rs_first v=%0d: got v=%b %h/%h expected pc4 %h", v, InstrValid, Instruction, PCPlus4Address, tgt + 32'd4);
                    end
                end
            end
        end
    endtask

    task automatic test_wrap();
        slow_addr = NO_SLOW;
        mem_rand = 1'b0;
        apply_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        drive_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imem_bus.ImemAddr !== 32'hFFFF_FFFC || InstrValid !== 1'b0) begin
            errors++; $display("FAIL wrap_addr: got %h v=%b expected fffffffc/0", imem_bus.ImemAddr, InstrValid);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (InstrValid !== 1'b1 || PCPlus4Address !== 32'd0 || Instruction !== (32'hFFFF_FFFC ^ KEY)) begin
            errors++; $display("FAIL wrap_pc4: got v=%b %h/%h expected 1/%h/00000000", InstrValid, Instruction, PCPlus4Address, 32'hFFFF_FFFC ^ KEY);
        end
        checks++;
        if (imem_bus.ImemAddr !== 32'd0) begin
            errors++; $display("FAIL wrap_next: got %h expected 00000000", imem_bus.ImemAddr);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (PCPlus4Address !== 32'd4 || Instruction !== KEY) begin
            errors++; $display("FAIL wrap_after: got %h/%h expected %h/00000004", Instruction, PCPlus4Address, KEY);
        end
    endtask

    task automatic test_reset_drain();
        slow_addr = 32'h10;
        slow_lat  = 5;
        mem_rand  = 1'b0;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            drive_cycle((k != 5), 1'b0, (k == 4), 32'h0000_0080);
            if (k == 4) begin
                checks++;
                if (imem_bus.ImemAddr !== 32'h10 || imem_bus.ImemAck !== 1'b0) begin
                    errors++; $display("FAIL rst_drain_setup: got addr %h ack %b expected 10/0", imem_bus.ImemAddr, imem_bus.ImemAck);
                end
            end else if (k == 5) begin
                checks++;
                if (imem_bus.ImemReq !== 1'b0) begin
                    errors++; $display("FAIL rst_drain_req: got %b expected 0", imem_bus.ImemReq);
                end
            end else if (k == 6) begin
                checks++;
                if (imem_bus.ImemAddr !== RESET_PC || imem_bus.ImemReq !== 1'b1 || InstrValid !== 1'b0) begin
                    errors++; $display("FAIL rst_drain_after: got addr %h req %b v=%b expected %h/1/0", imem_bus.ImemAddr, imem_bus.ImemReq, InstrValid, RESET_PC);
                end
            end else if (k == 7) begin
                checks++;
                if (InstrValid !== 1'b1 || PCPlus4Address !== RESET_PC + 32'd4 || Instruction !== (RESET_PC ^ KEY)) begin
                    errors++; $display("FAIL rst_drain_first: got v=%b %h/%h expected pc4 %h", InstrValid, Instruction, PCPlus4Address, RESET_PC + 32'd4);
                end
            end
        end
        slow_addr = NO_SLOW;
    endtask

    // Random stall/redirect/latency; the model tracks only the program-order
    // PC that decode should see next and the memory data function.
    task automatic test_random();
        logic [31:0] exp_pc, tgt, p_addr, p_inst, p_pc4;
        logic        st, rd, p_req, p_ack, p_valid, p_stall, p_redirect, consumed;
        int          last_consume;
        slow_addr = NO_SLOW;
        mem_rand = 1'b1;
        apply_reset();
        exp_pc = RESET_PC;
        p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_stall = 1'b0; p_redirect = 1'b0;
        p_addr = 32'd0; p_inst = 32'd0; p_pc4 = 32'd0;
        last_consume = 0;
        for (int i = 0; i < 800; i++) begin
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 24) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_3FFF);
            drive_cycle(1'b1, st, rd, tgt);
            if (p_req && !p_ack) begin
                checks++;
                if (imem_bus.ImemAddr !== p_addr) begin
                    errors++; $display("FAIL rnd_addr_stable i=%0d: got %h expected %h", i, imem_bus.ImemAddr, p_addr);
                end
            end
            checks++;
            if (imem_bus.ImemAddr[1:0] !== 2'b00) begin
                errors++; $display("FAIL rnd_align i=%0d: got %h", i, imem_bus.ImemAddr);
            end
            if (p_redirect) begin
                checks++;
                if (InstrValid !== 1'b0) begin
                    errors++; $display("FAIL rnd_flush i=%0d: got valid %b expected 0", i, InstrValid);
                end
            end else if (p_valid && p_stall) begin
                checks++;
                if (InstrValid !== 1'b1 || Instruction !== p_inst || PCPlus4Address !== p_pc4) begin
                    errors++; $display("FAIL rnd_stall_hold i=%0d: got v=%b %h/%h expected 1/%h/%h", i, InstrValid, Instruction, PCPlus4Address, p_inst, p_pc4);
                end
            end
            if (InstrValid === 1'b1) begin
                checks++;
                if (Instruction !== ((PCPlus4Address - 32'd4) ^ KEY)) begin
                    errors++; $display("FAIL rnd_data i=%0d: got %h expected %h", i, Instruction, (PCPlus4Address - 32'd4) ^ KEY);
                end
            end
            consumed = (InstrValid === 1'b1) && !st && !rd;
            if (consumed) begin
                checks++;
                if (PCPlus4Address - 32'd4 !== exp_pc) begin
                    errors++; $display("FAIL rnd_order i=%0d: got pc %h expected %h", i, PCPlus4Address - 32'd4, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                last_consume = i;
            end
            if (rd) exp_pc = {tgt[31:2], 2'b00};
            checks++;
            if (i - last_consume > 80) begin
                errors++; $display("FAIL rnd_progress i=%0d: got no delivery for %0d cycles expected <= 80", i, i - last_consume);
                break;
            end
            p_req = imem_bus.ImemReq; p_ack = imem_bus.ImemAck; p_addr = imem_bus.ImemAddr;
            p_valid = InstrValid; p_inst = Instruction; p_pc4 = PCPlus4Address;
            p_stall = st; p_redirect = rd;
        end
        mem_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_stall_hold();
        test_redirect_drain();
        test_redirect_stall();
        test_wrap();
        test_reset_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
